load_store_unit: RTL and testbench

- MEM-stage access unit directly upstream of the byte-addressed, word-wide data memory.
- Converts the pipeline's byte/halfword/word load and store requests into whole-word memory reads and writes.
- Sub-word stores use a two-cycle read-modify-write (RMW); loads are sign- or zero-extended.
- Drives a stall back to the pipeline and flags misaligned or out-of-range accesses.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Brief    : Shared size encodings, FSM states and memory size default.
//  Revision : 1.0
// ============================================================================
package mem_pkg;

   localparam int MEM_BYTES_DEFAULT = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RMW_MERGE = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane_align
//  Brief    : Byte-lane extract/extend for loads and lane merge for stores.
//  Revision : 1.0
// ============================================================================
module lsu_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merged
);

   logic [4:0]  w_shamt;
   logic [31:0] w_shifted;
   logic [31:0] w_lane_mask;
   logic [31:0] w_mask;

   assign w_shamt     = {i_lane, 3'b000};
   assign w_shifted   = i_word >> w_shamt;
   assign w_lane_mask = (size_e'(i_size) == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
   assign w_mask      = w_lane_mask << w_shamt;

   always_comb begin
      o_load   = i_word;
      o_merged = i_wdata;
      case (size_e'(i_size))
         SZ_BYTE: o_load = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
         SZ_HALF: o_load = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         default: o_load = i_word;
      endcase
      case (size_e'(i_size))
         SZ_BYTE, SZ_HALF: o_merged = (i_word & ~w_mask) | ((i_wdata & w_lane_mask) << w_shamt);
         default:          o_merged = i_wdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : MEM-stage load/store unit with two-cycle RMW for sub-word stores.
//  Revision : 1.0
// ============================================================================
module load_store_unit
   import mem_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        fault_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        mem_write_o,
   output logic        mem_read_o,
   input  logic [31:0] mem_data_i
);

   state_e      r_state;
   state_e      w_next;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_size;
   logic        r_unsigned;

   logic [32:0] w_nbytes;
   logic [32:0] w_last;
   logic        w_fault;
   logic        w_fault_set;
   logic        w_capture;
   logic        w_load_done;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   always_comb begin
      case (size_e'(req_size_i))
         SZ_BYTE: w_nbytes = 33'd1;
         SZ_HALF: w_nbytes = 33'd2;
         default: w_nbytes = 33'd4;
      endcase
   end

   // 33-bit sum so addresses near 2^32 cannot wrap back into range
   assign w_last  = {1'b0, req_addr_i} + w_nbytes - 33'd1;
   assign w_fault = (size_e'(req_size_i) == SZ_ILL)
                 || ((size_e'(req_size_i) == SZ_HALF) && req_addr_i[0])
                 || ((size_e'(req_size_i) == SZ_WORD) && (req_addr_i[1:0] != 2'b00))
                 || (w_last >= 33'(MEM_BYTES));

   lsu_lane_align u_align (
      .i_word     (mem_data_i),
      .i_lane     (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_wdata    (r_wdata),
      .o_load     (w_load_data),
      .o_merged   (w_merged)
   );

   always_comb begin
      w_next      = r_state;
      mem_addr_o  = 32'd0;
      mem_data_o  = 32'd0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      stall_o     = 1'b0;
      w_fault_set = 1'b0;
      w_capture   = 1'b0;
      w_load_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid_i) begin
               if (w_fault) begin
                  w_fault_set = 1'b1;
               end else if (req_write_i && (size_e'(req_size_i) == SZ_WORD)) begin
                  mem_write_o = 1'b1;
                  mem_addr_o  = {req_addr_i[31:2], 2'b00};
                  mem_data_o  = req_wdata_i;
               end else begin
                  mem_read_o = 1'b1;
                  stall_o    = 1'b1;
                  mem_addr_o = {req_addr_i[31:2], 2'b00};
                  w_capture  = 1'b1;
                  w_next     = req_write_i ? RMW_MERGE : LOAD_WAIT;
               end
            end
         end
         LOAD_WAIT: begin
            stall_o     = 1'b1;
            w_load_done = 1'b1;
            w_next      = IDLE;
         end
         RMW_MERGE: begin
            stall_o     = 1'b1;
            mem_write_o = 1'b1;
            mem_addr_o  = {r_addr[31:2], 2'b00};
            mem_data_o  = w_merged;
            w_next      = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // Reset overrides everything, so a reset during RMW_MERGE drops the write
      if (rst_i) begin
         w_next      = IDLE;
         mem_addr_o  = 32'd0;
         mem_data_o  = 32'd0;
         mem_read_o  = 1'b0;
         mem_write_o = 1'b0;
         stall_o     = 1'b0;
         w_fault_set = 1'b0;
         w_capture   = 1'b0;
         w_load_done = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= IDLE;
         rdata_o       <= 32'd0;
         rdata_valid_o <= 1'b0;
         fault_o       <= 1'b0;
         r_addr        <= 32'd0;
         r_wdata       <= 32'd0;
         r_size        <= 2'd0;
         r_unsigned    <= 1'b0;
      end else begin
         r_state       <= w_next;
         rdata_valid_o <= w_load_done;
         fault_o       <= w_fault_set;
         if (w_load_done) begin
            rdata_o <= w_load_data;
         end
         if (w_capture) begin
            r_addr     <= req_addr_i;
            r_wdata    <= req_wdata_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Self-checking bench for load_store_unit with a byte-level model.
//  Revision : 1.0
// ============================================================================
module tb_load_store_unit;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_write_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        rdata_valid_o;
   logic        fault_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_write_o;
   logic        mem_read_o;
   logic [31:0] mem_data_i;

   load_store_unit #(.MEM_BYTES(32)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_write_i    (req_write_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .stall_o        (stall_o),
      .rdata_o        (rdata_o),
      .rdata_valid_o  (rdata_valid_o),
      .fault_o        (fault_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_write_o    (mem_write_o),
      .mem_read_o     (mem_read_o),
      .mem_data_i     (mem_data_i)
   );

   always #5 clk = ~clk;

   // Environment memory (8 words) seen by the DUT
   logic [31:0] tbmem [8];
   logic        preload;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 8; i++) tbmem[i] <= (i == 2) ? 32'h8899AABB : 32'd0;
      end else begin
         if (mem_write_o) tbmem[mem_addr_o[4:2]] <= mem_data_o;
         if (mem_read_o)  mem_data_i <= tbmem[mem_addr_o[4:2]];
      end
   end

   // Reference model: byte array plus last delivered load value
   logic [7:0]  mref [32];
   logic [31:0] last_rd;
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
      logic [63:0] last;
      last = {32'd0, a} + 64'(nbytes(sz)) - 64'd1;
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
          || (last >= 64'd32);
   endfunction

   function automatic logic [31:0] model_word(input int a);
      return {mref[a+3], mref[a+2], mref[a+1], mref[a]};
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input bit u, input logic [31:0] a);
      logic [31:0] v = 32'd0;
      int base = int'(a[4:0]);
      int n    = nbytes(sz);
      for (int i = 0; i < n; i++) v = v | (32'(mref[base+i]) << (8*i));
      if (!u && n == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!u && n == 2 && v[15]) v = v | 32'hFFFF0000;
      return v;
   endfunction

   task automatic drive(input bit v, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid_i = v; req_write_i = w; req_size_i = sz;
      req_unsigned_i = u; req_addr_i = a; req_wdata_i = d;
   endtask

   task automatic do_req(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                         input logic [31:0] d, input string tag,
                         output logic [31:0] rd, output bit flt);
      bit          f  = model_fault(sz, a);
      logic [31:0] al = a & ~32'd3;
      logic [31:0] exp;
      @(posedge clk); #1; drive(1'b1, w, sz, u, a, d); #2;
      if (f) begin
         chk({tag, ".c0.rd_wr_stall"}, {29'd0, mem_read_o, mem_write_o, stall_o}, 32'd0);
      end else if (w && sz == 2'd2) begin
         chk({tag, ".c0.rd_wr_stall"}, {29'd0, mem_read_o, mem_write_o, stall_o}, 32'b010);
         chk({tag, ".c0.addr"}, mem_addr_o, al);
         chk({tag, ".c0.wdata"}, mem_data_o, d);
         for (int i = 0; i < 4; i++) mref[int'(al[4:0])+i] = d[8*i +: 8];
      end else begin
         chk({tag, ".c0.rd_wr_stall"}, {29'd0, mem_read_o, mem_write_o, stall_o}, 32'b101);
         chk({tag, ".c0.addr"}, mem_addr_o, al);
         @(posedge clk); #3;
         if (w) begin
            for (int i = 0; i < nbytes(sz); i++) mref[int'(a[4:0])+i] = d[8*i +: 8];
            chk({tag, ".c1.rd_wr_stall"}, {29'd0, mem_read_o, mem_write_o, stall_o}, 32'b011);
            chk({tag, ".c1.addr"}, mem_addr_o, al);
            chk({tag, ".c1.merged"}, mem_data_o, model_word(int'(al[4:0])));
         end else begin
            chk({tag, ".c1.rd_wr_stall"}, {29'd0, mem_read_o, mem_write_o, stall_o}, 32'b001);
         end
      end
      @(posedge clk); #1; drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0); #2;
      rd  = rdata_o;
      flt = fault_o;
      chk({tag, ".fault"}, {31'd0, fault_o}, {31'd0, f});
      chk({tag, ".done.stall"}, {31'd0, stall_o}, 32'd0);
      if (!f && !w) begin
         exp = model_load(sz, u, a);
         chk({tag, ".rvalid"}, {31'd0, rdata_valid_o}, 32'd1);
         chk({tag, ".rdata"}, rdata_o, exp);
         last_rd = exp;
      end else begin
         chk({tag, ".rvalid"}, {31'd0, rdata_valid_o}, 32'd0);
         chk({tag, ".rdata_hold"}, rdata_o, last_rd);
      end
   endtask

   typedef struct {
      bit          w;
      logic [1:0]  sz;
      bit          u;
      logic [31:0] a;
      logic [31:0] d;
      bit          ef;
      bit          cr;
      logic [31:0] er;
   } vec_t;

   initial begin
      vec_t        vecs [12];
      logic [31:0] rd;
      bit          flt;

      vecs[0]  = '{0, 2'd0, 0, 32'h0B, 32'h0,        0, 1, 32'hFFFFFF88};
      vecs[1]  = '{0, 2'd1, 1, 32'h0A, 32'h0,        0, 1, 32'h00008899};
      vecs[2]  = '{0, 2'd1, 0, 32'h0A, 32'h0,        0, 1, 32'hFFFF8899};
      vecs[3]  = '{1, 2'd0, 0, 32'h09, 32'hFFFFFF5A, 0, 0, 32'h0};
      vecs[4]  = '{0, 2'd2, 0, 32'h08, 32'h0,        0, 1, 32'h88995ABB};
      vecs[5]  = '{1, 2'd2, 0, 32'h04, 32'h12345678, 0, 0, 32'h0};
      vecs[6]  = '{0, 2'd2, 0, 32'h04, 32'h0,        0, 1, 32'h12345678};
      vecs[7]  = '{0, 2'd1, 0, 32'h03, 32'h0,        1, 0, 32'h0};
      vecs[8]  = '{1, 2'd2, 0, 32'h1E, 32'hDEADBEEF, 1, 0, 32'h0};
      vecs[9]  = '{0, 2'd3, 0, 32'h00, 32'h0,        1, 0, 32'h0};
      vecs[10] = '{0, 2'd0, 1, 32'h0B, 32'h0,        0, 1, 32'h00000088};
      vecs[11] = '{1, 2'd1, 0, 32'h1E, 32'h0000BEEF, 0, 0, 32'h0};

      for (int i = 0; i < 32; i++) mref[i] = 8'h00;
      {mref[11], mref[10], mref[9], mref[8]} = 32'h8899AABB;
      last_rd = 32'd0;
      preload = 1'b1;
      rst_i   = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1; preload = 1'b0; rst_i = 1'b0; #2;

      chk("reset.rdata", rdata_o, 32'd0);
      chk("reset.flags", {28'd0, rdata_valid_o, fault_o, stall_o, mem_read_o | mem_write_o}, 32'd0);
      chk("reset.addr", mem_addr_o, 32'd0);

      // Reset lands in the merge cycle of an SH: the write must be dropped
      @(posedge clk); #1; drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h08, 32'h0000BEEF); #2;
      chk("rstrmw.c0.read", {31'd0, mem_read_o}, 32'd1);
      @(posedge clk); #1; rst_i = 1'b1; drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0); #2;
      chk("rstrmw.c1.strobes", {30'd0, mem_read_o, mem_write_o}, 32'd0);
      chk("rstrmw.c1.stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1; rst_i = 1'b0; #2;
      chk("rstrmw.post.flags", {28'd0, rdata_valid_o, fault_o, stall_o, mem_read_o | mem_write_o}, 32'd0);
      chk("rstrmw.post.rdata", rdata_o, 32'd0);
      chk("rstrmw.post.addr_data", mem_addr_o | mem_data_o, 32'd0);
      chk("rstrmw.mem08", tbmem[2], 32'h8899AABB);

      for (int i = 0; i < 12; i++) begin
         do_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d,
                $sformatf("vec%0d", i), rd, flt);
         chk($sformatf("vec%0d.tbl_fault", i), {31'd0, flt}, {31'd0, vecs[i].ef});
         if (vecs[i].cr) chk($sformatf("vec%0d.tbl_rdata", i), rd, vecs[i].er);
      end

      for (int k = 0; k < 300; k++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 35));
         do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                $sformatf("rnd%0d", k), rd, flt);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #3;
            chk($sformatf("rnd%0d.idle", k),
                {28'd0, rdata_valid_o, fault_o, stall_o, mem_read_o | mem_write_o}, 32'd0);
         end
      end

      @(posedge clk); #3;
      for (int i = 0; i < 8; i++) chk($sformatf("final.mem%0d", i), tbmem[i], model_word(4*i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
